// File: rtl/aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// aes_inv_key_sched
//
// Sequential AES-128 inverse key schedule. The engine loads the final round key
// (round 10) and steps the key expansion backwards. It presents round keys 10,
// 9, ..., 0 one per handshake. The round constant is regenerated in reverse
// order by dividing by x in GF(2^8), so the design needs no rcon table. A
// forward S-box is built in for SubWord.
//
// Ports
//   clk          in   1    system clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    request to begin; sampled only while idle
//   key_in       in   128  round-10 key, [127:96] = w0 (first byte in MSBs)
//   key_out      out  128  current round key, same byte order as key_in
//   round_out    out  4    round index of key_out (10 down to 0)
//   key_valid    out  1    key_out / round_out are valid
//   key_ready    in   1    consumer accepts key_out
//   busy         out  1    sequence in progress
//   done         out  1    one-cycle pulse after the round-0 key is accepted
//   dbg_state_o  out  1    FSM state (0 = idle, 1 = emitting)
//
// Handshake: a key transfers on a rising edge where key_valid and key_ready
// are both high. While key_valid is high and key_ready is low, key_out and
// round_out stay stable. key_valid never drops until its key has transferred.
// -----------------------------------------------------------------------------
module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   round_out,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         dbg_state_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [7:0] RCON_FIRST = 8'h36;
  localparam logic [3:0] ROUND_LAST = 4'd10;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  logic [127:0] key_q,   key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q,  rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;

  // ---------------------------------------------------------------------------
  // Inverse expansion step, purely combinational from key_q / rcon_q
  // ---------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3, sub_rot_p3;
  logic [127:0] prev_key;
  logic [7:0]   rcon_next;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // The last three words undo the chained XOR of the forward schedule.
  // p3 is the previous key's w3, so it feeds the g() function that rebuilds p0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  assign rot_p3     = {p3[23:0], p3[31:24]};
  assign sub_rot_p3 = {sbox(rot_p3[31:24]), sbox(rot_p3[23:16]),
                       sbox(rot_p3[15:8]),  sbox(rot_p3[7:0])};

  assign p0       = w0 ^ sub_rot_p3 ^ {rcon_q, 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  // Division by x in GF(2^8) mod x^8+x^4+x^3+x+1. When bit 0 is set, the
  // reduction polynomial is first folded in (0x11b -> 0x1b, with the x^8 term
  // reappearing as bit 7 after the shift).
  assign rcon_next = rcon_q[0] ? (((rcon_q ^ 8'h1b) >> 1) | 8'h80)
                               : (rcon_q >> 1);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = ROUND_LAST;
          rcon_d  = RCON_FIRST;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (valid_q && key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
            rcon_d  = rcon_next;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= RCON_FIRST;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_out     = key_q;
  assign round_out   = round_q;
  assign key_valid   = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = (state_q == ST_EMIT);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_key_sched
//
// Self-checking bench for aes_inv_key_sched. The reference model expands a
// round-0 key forwards using an S-box derived from GF(2^8) inversion plus the
// affine map. It then queues the round keys in reverse order as the
// expected stream.
// -----------------------------------------------------------------------------
module tb_aes_inv_key_sched;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         key_valid;
  logic         key_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         dbg_state;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .key_out     (key_out),
    .round_out   (round_out),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [127:0] exp_q[$];
  logic [127:0] got_keys[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: forward AES-128 key expansion
  // ---------------------------------------------------------------------------
  logic [7:0]   sb [0:255];
  logic [127:0] rk [0:10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    t = t << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (a != 0 && gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] g_word(input logic [31:0] w, input logic [7:0] rc);
    logic [31:0] r = {w[23:0], w[31:24]};
    return {sb[r[31:24]] ^ rc, sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ g_word(w[i-1], rc);
        rc = gmul(rc, 8'h02);
      end else begin
        w[i] = w[i-4] ^ w[i-1];
      end
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_expected();
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back(rk[r]);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at #1 after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic start_key(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = rand128();   // later changes must not matter
  endtask

  // Consumes the expected stream. ready_pct sets the key_ready probability;
  // a stray start is pulsed once when round_out equals glitch_round.
  // Returns positioned just after the edge that accepted the round-0 key.
  task automatic consume(input int ready_pct, input int glitch_round);
    int           budget = 400;
    int           exp_round = 10;
    bit           held_v = 1'b0;
    bit           glitched = 1'b0;
    logic [127:0] held_key = '0;
    logic [3:0]   held_round = '0;
    got_keys.delete();
    while (exp_q.size() > 0 && budget > 0) begin
      if (key_valid) begin
        check("busy_high", 128'(busy), 128'(1));
        check("done_low", 128'(done), 128'(0));
        if (held_v) begin
          check("hold_key", key_out, held_key);
          check("hold_round", 128'(round_out), 128'(held_round));
        end
        if (!glitched && int'(round_out) == glitch_round) begin
          start = 1'b1;
          key_in = rand128();
          glitched = 1'b1;
        end
        key_ready = ($urandom_range(0, 99) < ready_pct);
        if (key_ready) begin
          got_keys.push_back(key_out);
          check($sformatf("key_r%0d", exp_round), key_out, exp_q.pop_front());
          check("round", 128'(round_out), 128'(exp_round));
          exp_round--;
          held_v = 1'b0;
        end else begin
          held_v     = 1'b1;
          held_key   = key_out;
          held_round = round_out;
        end
      end else begin
        key_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      start = 1'b0;
      budget--;
    end
    if (budget == 0) check("timeout", 128'(0), 128'(1));
    key_ready = 1'b0;
    check("done_pulse", 128'(done), 128'(1));
    check("valid_end", 128'(key_valid), 128'(0));
    check("busy_end", 128'(busy), 128'(0));
  endtask

  // One more cycle in idle: done must have been a single-cycle pulse.
  task automatic settle_idle();
    @(posedge clk); #1;
    check("done_once", 128'(done), 128'(0));
    check("idle_valid", 128'(key_valid), 128'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  localparam logic [127:0] A1_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  initial begin
    build_sbox();

    // Reset state
    #12;
    check("rst_key", key_out, 128'(0));
    check("rst_round", 128'(round_out), 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1, ready tied high
    expand(A1_K0);
    load_expected();
    start_key(A1_K10);
    consume(100, -1);
    check("a1_r10", got_keys[0], A1_K10);
    check("a1_r9", got_keys[1], A1_K9);
    check("a1_r1", got_keys[9], A1_K1);
    check("a1_r0", got_keys[10], A1_K0);
    settle_idle();

    // Backpressure
    load_expected();
    start_key(A1_K10);
    consume(50, -1);
    settle_idle();

    // Stray start while busy
    load_expected();
    start_key(A1_K10);
    consume(70, 5);
    settle_idle();

    // Async reset mid-run at round 4
    load_expected();
    start_key(A1_K10);
    key_ready = 1'b1;
    for (int i = 0; i < 30 && round_out != 4'd4; i++) begin
      @(posedge clk); #1;
    end
    check("reached_r4", 128'(round_out), 128'(4));
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(key_valid), 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
    check("arst_done", 128'(done), 128'(0));
    check("arst_round", 128'(round_out), 128'(0));
    check("arst_key", key_out, 128'(0));
    key_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    load_expected();
    start_key(A1_K10);
    consume(100, -1);
    settle_idle();

    // Random keys, random backpressure; every other one back-to-back
    for (int n = 0; n < 100; n++) begin
      expand(rand128());
      load_expected();
      start_key(rk[10]);
      consume(int'($urandom_range(30, 100)), -1);
      if (n % 2 == 0) settle_idle();
    end
    settle_idle();

    // Explicit back-to-back: start in the done cycle with a new key
    expand(A1_K0);
    load_expected();
    start_key(A1_K10);
    consume(100, -1);
    expand(rand128());
    load_expected();
    start_key(rk[10]);
    check("b2b_round", 128'(round_out), 128'(10));
    check("b2b_first", key_out, rk[10]);
    consume(100, -1);
    settle_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
